// File: rtl/cpe_pkg.sv
// Shared types and sizes for the branch compare unit.
// BRCMP_EARLY_EXIT_EN (optional) lets SCAN stop at the first differing chunk.
package cpe_pkg;

  localparam int XLEN       = 32;
  localparam int CHUNK_W    = 4;
  localparam int NUM_CHUNKS = 8;
  localparam int IDX_W      = $clog2(NUM_CHUNKS);

  typedef enum logic [1:0] {
    BRCMP_IDLE = 2'd0,
    BRCMP_SCAN = 2'd1,
    BRCMP_DONE = 2'd2
  } brcmp_state_e;

endpackage

// File: rtl/brcmp_chunk.sv
// Combinational unsigned compare of one operand chunk.
// Used by branch_compare_unit once per SCAN cycle.
module brcmp_chunk
  import cpe_pkg::*;
(
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  output logic               chunk_eq,
  output logic               chunk_lt
);

  assign chunk_eq = (a == b);
  assign chunk_lt = (a < b);

endmodule

// File: rtl/branch_compare_unit.sv
// Multi-cycle branch comparator, one 4-bit chunk per cycle, MSB first.
// Build option: BRCMP_EARLY_EXIT_EN ends SCAN at the first differing chunk.
module branch_compare_unit
  import cpe_pkg::*;
(
  input  logic            clk_w_i,
  input  logic            rst_w_i_l,
  input  logic            start_w_i_h,
  input  logic [XLEN-1:0] rs1_w_i,
  input  logic [XLEN-1:0] rs2_w_i,
  input  logic            flush_w_i_h,
  output logic            busy_w_o_h,
  output logic            done_w_o_h,
  output logic            flags_valid_w_o_h,
  output logic            eq_w_o_h,
  output logic            lts_w_o_h,
  output logic            ltu_w_o_h,
  output logic            gtes_w_o_h,
  output logic            gteu_w_o_h
);

  brcmp_state_e state, state_nxt;

  logic [XLEN-1:0]    a_q, b_q;
  logic [IDX_W-1:0]   idx_q;
  logic               found_q, lt_q;
  logic [CHUNK_W-1:0] a_ch, b_ch;
  logic               chunk_eq, chunk_lt;
  logic               accept, in_scan;
  logic               hit, last, exit_scan;
  logic               lt_now, lts_now, eq_now;

  assign a_ch = a_q[idx_q*CHUNK_W +: CHUNK_W];
  assign b_ch = b_q[idx_q*CHUNK_W +: CHUNK_W];

  brcmp_chunk u_chunk (
    .a        (a_ch),
    .b        (b_ch),
    .chunk_eq (chunk_eq),
    .chunk_lt (chunk_lt)
  );

  assign in_scan = (state == BRCMP_SCAN);
  assign accept  = start_w_i_h & ~flush_w_i_h & ~in_scan;
  assign hit     = ~found_q & ~chunk_eq;
  assign last    = (idx_q == '0);

`ifdef BRCMP_EARLY_EXIT_EN
  assign exit_scan = last | hit;
`else
  assign exit_scan = last;
`endif

  // First differing chunk decides the unsigned order.
  assign lt_now  = found_q ? lt_q : (hit & chunk_lt);
  assign eq_now  = ~found_q & chunk_eq;
  assign lts_now = (a_q[XLEN-1] ^ b_q[XLEN-1]) ?
                   a_q[XLEN-1] : lt_now;

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) state <= BRCMP_IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_w_i_h) begin
      state_nxt = BRCMP_IDLE;
    end else begin
      unique case (state)
        BRCMP_IDLE:
          if (accept) state_nxt = BRCMP_SCAN;
        BRCMP_SCAN:
          if (exit_scan) state_nxt = BRCMP_DONE;
        BRCMP_DONE:
          state_nxt = accept ? BRCMP_SCAN : BRCMP_IDLE;
        default:
          state_nxt = BRCMP_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      a_q               <= '0;
      b_q               <= '0;
      idx_q             <= '0;
      found_q           <= 1'b0;
      lt_q              <= 1'b0;
      flags_valid_w_o_h <= 1'b0;
      eq_w_o_h          <= 1'b0;
      lts_w_o_h         <= 1'b0;
      ltu_w_o_h         <= 1'b0;
      gtes_w_o_h        <= 1'b0;
      gteu_w_o_h        <= 1'b0;
    end else if (accept) begin
      a_q               <= rs1_w_i;
      b_q               <= rs2_w_i;
      idx_q             <= IDX_W'(NUM_CHUNKS - 1);
      found_q           <= 1'b0;
      lt_q              <= 1'b0;
      flags_valid_w_o_h <= 1'b0;
    end else if (in_scan && !flush_w_i_h) begin
      if (hit) begin
        found_q <= 1'b1;
        lt_q    <= chunk_lt;
      end
      if (exit_scan) begin
        flags_valid_w_o_h <= 1'b1;
        eq_w_o_h          <= eq_now;
        ltu_w_o_h         <= lt_now;
        gteu_w_o_h        <= ~lt_now;
        lts_w_o_h         <= lts_now;
        gtes_w_o_h        <= ~lts_now;
      end else begin
        idx_q <= idx_q - 1'b1;
      end
    end
  end

  assign busy_w_o_h = in_scan;
  assign done_w_o_h = (state == BRCMP_DONE);

endmodule

// File: doc/branch_compare_unit.md
BRANCH_COMPARE_UNIT -- requirements
Module: branch_compare_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk_w_i input 1, rising-edge clock; rst_w_i_l input 1, asynchronous active-low reset.
REQ-002 SHALL have port start_w_i_h input 1: request to compare, sampled on the rising edge.
REQ-003 SHALL have port rs1_w_i input 32: operand A, sampled with start.
REQ-004 SHALL have port rs2_w_i input 32: operand B, sampled with start.
REQ-005 SHALL have port flush_w_i_h input 1: pipeline kill that aborts an in-flight compare.
REQ-006 SHALL have port busy_w_o_h output 1: a compare is in progress (SCAN state).
REQ-007 SHALL have port done_w_o_h output 1: one-cycle pulse marking that the flags were just updated.
REQ-008 SHALL have port flags_valid_w_o_h output 1: the flags hold the result of the last accepted compare.
REQ-009 SHALL have ports eq_w_o_h, lts_w_o_h, ltu_w_o_h, gtes_w_o_h, gteu_w_o_h, each output 1: registered comparison flags for the branch-condition consumer.

Function
REQ-010 SHALL implement the FSM states IDLE, SCAN and DONE; start SHALL be accepted only in IDLE or DONE, and start while in SCAN SHALL be ignored.
REQ-011 On accept, SHALL capture both operands, clear flags_valid_w_o_h, load the chunk index with 7, and enter SCAN.
REQ-012 In SCAN, SHALL compare one 4-bit chunk per cycle, MSB chunk (bits 31:28) first, down to chunk 0.
REQ-013 SHALL set ltu from the first chunk (MSB-first) in which the operands differ; equal operands SHALL give eq=1 and ltu=0.
REQ-014 SHALL compute lts as rs1[31] when rs1[31] differs from rs2[31], and as ltu otherwise.
REQ-015 SHALL drive gteu as ~ltu and gtes as ~lts; exactly one of ltu/gteu and exactly one of lts/gtes SHALL be high whenever flags are valid.
REQ-016 With the macro BRCMP_EARLY_EXIT_EN undefined, SCAN SHALL last exactly 8 cycles: start sampled at edge E0, flags registered at E8, done_w_o_h high in the cycle following E8.
REQ-017 On leaving SCAN, the FSM SHALL enter DONE for one cycle, with done_w_o_h=1 and flags_valid_w_o_h=1, and then go to IDLE.
REQ-018 The flags and flags_valid_w_o_h SHALL hold their values until the next accepted start.
REQ-019 Back-to-back operation: a start in DONE SHALL be accepted, giving a throughput of one compare per 9 cycles worst case.
REQ-020 flush_w_i_h SHALL force IDLE on the next edge from any state; when it aborts a SCAN, no done pulse SHALL be produced and flags_valid_w_o_h SHALL stay 0.
REQ-021 When flush_w_i_h and start_w_i_h are high together, flush SHALL win and the start SHALL be dropped.
REQ-022 The chunk index SHALL never wrap: the compare SHALL terminate when index 0 is processed.

Reset
REQ-023 Asserting rst_w_i_l low SHALL immediately force IDLE and drive busy, done, flags_valid, eq, lts, ltu, gtes and gteu to 0, from any state.
REQ-024 A reset asserted mid-SCAN SHALL discard the operation, with no done pulse after the reset is released.

Configuration
REQ-025 BRCMP_EARLY_EXIT_EN defined: SCAN SHALL exit to DONE at the edge that evaluates the first differing chunk, giving a latency of k+1 edges where k is that chunk's position counted from the MSB (0..7).
REQ-026 With BRCMP_EARLY_EXIT_EN defined, equal operands SHALL still take the full 8 cycles.
REQ-027 BRCMP_EARLY_EXIT_EN undefined: SCAN SHALL always take 8 cycles, and the flags SHALL be identical in both builds.

Structure
REQ-028 The shared package cpe_pkg SHALL hold XLEN=32, CHUNK_W=4, NUM_CHUNKS=8 and the encodings BRCMP_IDLE/SCAN/DONE.
REQ-029 The block SHALL contain one sub-module, brcmp_chunk: a combinational 4-bit compare that outputs chunk_eq and chunk_lt (unsigned).
REQ-030 The branch-condition consumer SHALL qualify its inputs with flags_valid_w_o_h.

Verification
REQ-031 rs1=0x8000_0000, rs2=0x0000_0001 -> eq=0, ltu=0, gteu=1, lts=1, gtes=0; done 1 cycle after E1 with BRCMP_EARLY_EXIT_EN, 1 cycle after E8 without.
REQ-032 rs1=rs2=0x1234_5678 -> eq=1, ltu=0, lts=0, gteu=1, gtes=1; done after E8 in both builds.
REQ-033 rs1=0x0000_0010, rs2=0x0000_0011 -> ltu=1, lts=1, eq=0; in the BRCMP_EARLY_EXIT_EN build, done after E8 (difference only in chunk 0).
REQ-034 Start, then flush at E3, then a new start at E5 with rs1=0xFFFF_FFFF, rs2=0 -> no done for the first compare; the second compare gives ltu=0, lts=1.
REQ-035 rst_w_i_l pulsed low at E4 mid-SCAN -> all outputs 0 immediately, and no done after release.
REQ-036 Start held high continuously -> starts during SCAN are ignored, accepts occur only in DONE/IDLE, and one done pulse occurs per compare.
